// File: rtl/cmp_stat_collector.sv
`default_nettype none
// ============================================================================
// Module   : cmp_stat_collector
// Purpose  : Collects comparator results (less/greater/equal) over a window
//            of WINDOW accepted samples. At the end of each window it presents
//            the per-flag counts and a sticky "not one-hot" error bit through a
//            valid/ready report interface.
// Ports    : clk          - rising-edge clock
//            rst_n        - synchronous active-low reset
//            in_valid     - result present on less/greater/equal
//            in_ready     - block accepts a result this cycle (COLLECT state)
//            less/greater/equal - comparator result flags
//            rep_valid    - window report present (REPORT state)
//            rep_ready    - consumer accepts the report
//            cnt_less/cnt_greater/cnt_equal - per-window counts (CNT_W bits)
//            onehot_err   - some sample in the window was not one-hot
// Revision : 1.0 - initial release
// ============================================================================
module cmp_stat_collector #(
    parameter int WINDOW = 16,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             less,
    input  logic             greater,
    input  logic             equal,
    output logic             rep_valid,
    input  logic             rep_ready,
    output logic [CNT_W-1:0] cnt_less,
    output logic [CNT_W-1:0] cnt_greater,
    output logic [CNT_W-1:0] cnt_equal,
    output logic             onehot_err
);

    localparam int               SMP_W        = $clog2(WINDOW + 1);
    localparam logic [SMP_W-1:0] c_LAST       = SMP_W'(WINDOW - 1);
    localparam logic [SMP_W-1:0] c_SMP_ONE    = SMP_W'(1);
    localparam logic [CNT_W-1:0] c_MAX        = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_ONE        = CNT_W'(1);

    localparam logic [0:0]       c_ST_COLLECT = 1'b0;
    localparam logic [0:0]       c_ST_REPORT  = 1'b1;

    logic [0:0]       r_state;
    logic [0:0]       w_state_nxt;

    logic [SMP_W-1:0] r_smp;
    logic [CNT_W-1:0] r_less;
    logic [CNT_W-1:0] r_greater;
    logic [CNT_W-1:0] r_equal;
    logic             r_err;

    logic             w_accept;
    logic             w_last;
    logic             w_onehot;
    logic [CNT_W-1:0] w_nxt_less;
    logic [CNT_W-1:0] w_nxt_greater;
    logic [CNT_W-1:0] w_nxt_equal;
    logic             w_nxt_err;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_ST_COLLECT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_COLLECT: if (w_accept && w_last) w_state_nxt = c_ST_REPORT;
            c_ST_REPORT:  if (rep_ready)          w_state_nxt = c_ST_COLLECT;
            default:                              w_state_nxt = c_ST_COLLECT;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        in_ready  = 1'b0;
        rep_valid = 1'b0;
        case (r_state)
            c_ST_COLLECT: in_ready  = 1'b1;
            c_ST_REPORT:  rep_valid = 1'b1;
            default:      in_ready  = 1'b0;
        endcase
    end

    // ---------------- Datapath ----------------
    assign w_accept = in_valid & in_ready;
    assign w_last   = (r_smp == c_LAST);

    // Exactly one flag set: odd parity rules out 000/011/101/110, and the
    // AND term rules out 111.
    assign w_onehot = (less ^ greater ^ equal) & ~(less & greater & equal);

    // Counter values including the current sample, saturating at all-ones.
    // These feed both the live counters and the report registers so the
    // final sample of a window is included in its report.
    always_comb begin
        w_nxt_less    = r_less;
        w_nxt_greater = r_greater;
        w_nxt_equal   = r_equal;
        if (w_accept && w_onehot) begin
            if (less && (r_less != c_MAX))
                w_nxt_less = r_less + c_ONE;
            if (greater && (r_greater != c_MAX))
                w_nxt_greater = r_greater + c_ONE;
            if (equal && (r_equal != c_MAX))
                w_nxt_equal = r_equal + c_ONE;
        end
    end

    assign w_nxt_err = r_err | (w_accept & ~w_onehot);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_smp       <= '0;
            r_less      <= '0;
            r_greater   <= '0;
            r_equal     <= '0;
            r_err       <= 1'b0;
            cnt_less    <= '0;
            cnt_greater <= '0;
            cnt_equal   <= '0;
            onehot_err  <= 1'b0;
        end else if (w_accept) begin
            if (w_last) begin
                cnt_less    <= w_nxt_less;
                cnt_greater <= w_nxt_greater;
                cnt_equal   <= w_nxt_equal;
                onehot_err  <= w_nxt_err;
                r_smp       <= '0;
                r_less      <= '0;
                r_greater   <= '0;
                r_equal     <= '0;
                r_err       <= 1'b0;
            end else begin
                r_smp       <= r_smp + c_SMP_ONE;
                r_less      <= w_nxt_less;
                r_greater   <= w_nxt_greater;
                r_equal     <= w_nxt_equal;
                r_err       <= w_nxt_err;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/cmp_stat_collector.md
CMP_STAT_COLLECTOR -- requirements
Module: cmp_stat_collector

Interface
REQ-001 The block SHALL have parameter WINDOW, default 16: number of accepted comparison results per report window, legal range 1 to 65535.
REQ-002 The block SHALL have parameter CNT_W, default 8: width of each result counter, legal range 1 to 16.
REQ-003 The block SHALL use one clock and a synchronous, active-low reset: port clk, input, 1 bit, rising-edge clock for all state.
REQ-004 Port rst_n, input, 1 bit: synchronous active-low reset, sampled on the rising edge of clk.
REQ-005 Port in_valid, input, 1 bit: a comparison result is present on less/greater/equal.
REQ-006 Port in_ready, output, 1 bit: the block accepts a result this cycle.
REQ-007 Ports less, greater, equal, input, 1 bit each: result flags from the 8-bit comparator stage.
REQ-008 Port rep_valid, output, 1 bit: a window report is present on the report outputs.
REQ-009 Port rep_ready, input, 1 bit: the consumer accepts the report this cycle.
REQ-010 Ports cnt_less, cnt_greater, cnt_equal, output, CNT_W bits each: per-window result counts.
REQ-011 Port onehot_err, output, 1 bit: at least one sample in the reported window was not exactly one-hot.

Function
REQ-012 The state machine SHALL have two states: COLLECT and REPORT.
REQ-013 In COLLECT: in_ready=1 and rep_valid=0.
REQ-014 In REPORT: in_ready=0 and rep_valid=1.
REQ-015 Accept SHALL occur when in_valid=1 and in_ready=1 on a rising clk edge; no accept occurs on any other cycle.
REQ-016 On accept, the live counter selected by the flag SHALL increment by 1 if exactly one of less/greater/equal is 1.
REQ-017 If the flags are not exactly one-hot (000, 011, 101, 110 or 111), no counter SHALL increment and a sticky window error bit SHALL be set.
REQ-018 Every accept, legal or not, SHALL increment a sample counter of width ceil(log2(WINDOW+1)).
REQ-019 Live counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-020 Gaps in in_valid SHALL be allowed: idle cycles change no state.
REQ-021 On the accept that completes the window (sample counter = WINDOW-1), the block SHALL:
- load cnt_less, cnt_greater, cnt_equal and onehot_err with the counts, including that final sample;
- clear the live counters, the sample counter and the sticky error bit;
- enter REPORT on the next cycle.
Report latency is therefore exactly 1 cycle after the final accept.
REQ-022 In REPORT, the report outputs SHALL be held stable and in_valid SHALL be ignored (backpressure) for as long as rep_ready=0.
REQ-023 When rep_valid=1 and rep_ready=1, the block SHALL return to COLLECT on the next cycle, with in_ready=1 from that cycle.
REQ-024 After handshake, the report outputs SHALL hold their last values until the next window load.
REQ-025 With WINDOW=1, every accept SHALL produce a report; the maximum sustained throughput is then one sample per 2 cycles.
REQ-026 rep_ready asserted while in COLLECT SHALL have no effect.

Reset
REQ-027 While rst_n=0 at a clk edge, the block SHALL:
- enter COLLECT;
- clear the live counters, the sample counter and the sticky error bit;
- drive rep_valid=0, cnt_less=0, cnt_greater=0, cnt_equal=0 and onehot_err=0.
in_ready SHALL be 1 from the first cycle after rst_n=1.
REQ-028 Reset mid-window or during REPORT SHALL discard the partial window or the pending report; no report SHALL be emitted for it.

Verification (WINDOW=4, CNT_W=8 unless stated)
REQ-029 Reset: hold rst_n=0 for 2 cycles with random inputs -> all outputs 0 and in_ready=0 is never observed after release; in_ready=1 on the first post-reset cycle.
REQ-030 Basic window: accept greater, less, equal, greater back-to-back -> 1 cycle later rep_valid=1, cnt_greater=2, cnt_less=1, cnt_equal=1, onehot_err=0.
REQ-031 Backpressure: at report, hold rep_ready=0 for 5 cycles while in_valid=1 -> rep_valid and counts unchanged, in_ready=0, no samples counted. Then pulse rep_ready=1 -> next cycle rep_valid=0, in_ready=1.
REQ-032 Non-one-hot input: window containing flags 110 plus greater, greater, less -> onehot_err=1, cnt_greater=2, cnt_less=1, cnt_equal=0.
REQ-033 Saturation: WINDOW=300, CNT_W=8, all samples greater with random in_valid gaps -> cnt_greater=255, cnt_less=0, cnt_equal=0.
REQ-034 Reset mid-window: accept 2 samples, pulse rst_n=0 for 1 cycle, then accept equal x4 -> report cnt_equal=4, all other counts 0, onehot_err=0.
